cache_flush_ctrl: RTL and testbench
===================================

// Module: cache_flush_ctrl
// PURPOSE
//   Clear-side sequencer for the cache valid/dirty storage. The fill path sets valid bits; this block removes them.
//   It handles two kinds of request:
//     - a full flush, which walks every (index, way);
//     - a single-line invalidate.
//   Dirty lines are written back through a valid/ready handshake before they are cleared.
//   Sits between the cache controller and the valid/dirty arrays. Asserts busy so the controller stalls fills and lookups.
// PARAMETERS
//   WAYS        4   associativity; power of 2, >=2
//   TOTAL_SIZE  16  total lines; SETS = TOTAL_SIZE/WAYS, power of 2, >=2
//   IW = $clog2(SETS), WW = $clog2(WAYS) (localparams)
// PORTS
//   clk            in   1    clock
//   rst            in   1    reset, asynchronous, active-high
//   flush_start    in   1    pulse: begin full flush; accepted only in IDLE
//   inv_valid      in   1    single-line invalidate request
//   inv_ready      out  1    request accepted when inv_valid && inv_ready
//   inv_index      in   IW   set index to invalidate
//   inv_way        in   WW   way to invalidate
//   rd_index       out  IW   index driven to the valid/dirty arrays (combinational read)
//   valid_in       in   WAYS valid bits for rd_index, bit w = way w
//   dirty_in       in   WAYS dirty bits for rd_index
//   clr_we         out  1    clear valid+dirty of (clr_index, clr_way) at this posedge
//   clr_index      out  IW   line index to clear
//   clr_way        out  WW   line way to clear
//   wb_valid       out  1    writeback request for (wb_index, wb_way)
//   wb_ready       in   1    writeback accepted
//   wb_index       out  IW   writeback line index
//   wb_way         out  WW   writeback line way
//   busy           out  1    high in every state except IDLE
//   done           out  1    1-cycle pulse when a flush or line invalidate completes
// BEHAVIOUR
//   States: IDLE, SCAN, LINE, WB, DONE. Reset -> IDLE, counters 0.
//   Outputs at reset: all outputs 0, except rd_index = 0.
//   Reset mid-operation aborts immediately with no further clr_we or wb_valid.
//   IDLE: inv_ready = !flush_start.
//     - flush_start -> SCAN with cur_index = 0, cur_way = 0.
//     - Otherwise, inv_valid -> LINE, latching inv_index and inv_way.
//     - When both arrive in the same cycle, the flush wins and the line request is not accepted.
//   rd_index = cur_index in SCAN, LINE and WB.
//   SCAN and LINE evaluate line L = (cur_index, cur_way) as follows:
//     - !valid_in[w]: no action. Advance.
//     - valid && !dirty: clr_we = 1 in the same cycle. Advance.
//     - valid && dirty: go to WB. No clear yet.
//   WB: wb_valid = 1 with wb_index and wb_way = L, held stable until wb_ready.
//     - wb_valid never drops before the handshake completes.
//     - On the handshake cycle, clr_we = 1 for L, then advance.
//   Advance, SCAN:
//     - cur_way increments first. When it wraps from WAYS-1 to 0, cur_index increments.
//     - The line (SETS-1, WAYS-1) is last -> DONE.
//   Advance, LINE: -> DONE.
//   DONE: done = 1 for one cycle, busy = 1. Next state IDLE.
//   Latency for an all-clean or all-invalid cache:
//     - flush: busy for SETS*WAYS + 1 cycles (SCAN cycles plus DONE);
//     - line: busy for 2 cycles.
//   Each dirty line adds at least one WB cycle (one per wb_ready stall cycle).
//   flush_start and inv_valid are ignored while busy.
//   A fill to the arrays while busy is a protocol violation; the bench asserts that it never happens.
//   clr_we is never asserted together with wb_valid unless wb_ready is also high.
//   Counters are exactly IW/WW bits wide and wrap naturally. There is no off-by-one at the last index.
// TESTING
//   1. All invalid, WAYS=4, SETS=4, flush_start -> busy for 17 cycles, no clr_we, no wb_valid, done at cycle 17.
//   2. All lines valid and clean, flush -> 16 clr_we pulses in order (0,0),(0,1)..(3,3); done follows the (3,3) clear.
//   3. Line (2,1) valid and dirty, wb_ready low for 3 cycles -> wb_valid held 4 cycles at (2,1); clr_we (2,1) on the handshake; scan resumes at (2,2).
//   4. inv_valid at (1,3), line valid and clean -> inv_ready=1, clr_we (1,3) next cycle, done the cycle after; other lines untouched.
//   5. flush_start and inv_valid in the same cycle -> flush runs, inv_ready=0; the line request is accepted after done.
//   6. rst asserted during WB at (0,2) -> wb_valid, clr_we and busy are 0 immediately; IDLE; a new flush starts at (0,0).

Source files
------------

// File: rtl/cache_flush_ctrl.sv
// Clear-side sequencer for the cache valid/dirty arrays: full flush walk or single-line
// invalidate, with dirty lines written back over a valid/ready handshake before clearing.
module cache_flush_ctrl #(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned TOTAL_SIZE = 16,
  localparam int unsigned SETS      = TOTAL_SIZE / WAYS,
  localparam int unsigned IW        = $clog2(SETS),
  localparam int unsigned WW        = $clog2(WAYS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_start,
  input  logic            inv_valid,
  output logic            inv_ready,
  input  logic [IW-1:0]   inv_index,
  input  logic [WW-1:0]   inv_way,
  output logic [IW-1:0]   rd_index,
  input  logic [WAYS-1:0] valid_in,
  input  logic [WAYS-1:0] dirty_in,
  output logic            clr_we,
  output logic [IW-1:0]   clr_index,
  output logic [WW-1:0]   clr_way,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [IW-1:0]   wb_index,
  output logic [WW-1:0]   wb_way,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    LINE,
    WB,
    DONE
  } state_e;

  localparam logic [IW-1:0] LAST_INDEX = IW'(SETS - 1);
  localparam logic [WW-1:0] LAST_WAY   = WW'(WAYS - 1);

  state_e        state_q;
  logic [IW-1:0] cur_index_q;
  logic [WW-1:0] cur_way_q;
  logic          is_flush_q;
  logic          busy_q;
  logic          done_q;
  logic          wb_valid_q;

  logic scanning;
  logic line_valid;
  logic line_dirty;
  logic to_wb;
  logic advance;
  logic last_line;

  always_comb begin
    scanning   = (state_q == SCAN) || (state_q == LINE);
    line_valid = valid_in[cur_way_q];
    line_dirty = dirty_in[cur_way_q];
    to_wb      = scanning && line_valid && line_dirty;
    // A clean or invalid line advances immediately; a dirty one only after its handshake.
    advance    = (scanning && !(line_valid && line_dirty)) ||
                 ((state_q == WB) && wb_ready);
    last_line  = (cur_index_q == LAST_INDEX) && (cur_way_q == LAST_WAY);
  end

  always_comb begin
    clr_we = (scanning && line_valid && !line_dirty) || ((state_q == WB) && wb_ready);
    // Gated by rst so the ready flag also reads 0 while reset is held.
    inv_ready = (state_q == IDLE) && !flush_start && !rst;
    rd_index  = (scanning || (state_q == WB)) ? cur_index_q : '0;
  end

  assign clr_index = cur_index_q;
  assign clr_way   = cur_way_q;
  assign wb_index  = cur_index_q;
  assign wb_way    = cur_way_q;
  assign wb_valid  = wb_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_index_q <= '0;
      cur_way_q   <= '0;
      is_flush_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wb_valid_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush_start) begin
            state_q     <= SCAN;
            cur_index_q <= '0;
            cur_way_q   <= '0;
            is_flush_q  <= 1'b1;
            busy_q      <= 1'b1;
          end else if (inv_valid) begin
            state_q     <= LINE;
            cur_index_q <= inv_index;
            cur_way_q   <= inv_way;
            is_flush_q  <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        SCAN, LINE, WB: begin
          if (to_wb) begin
            state_q    <= WB;
            wb_valid_q <= 1'b1;
          end else if (advance) begin
            wb_valid_q <= 1'b0;
            if (is_flush_q && !last_line) begin
              state_q   <= SCAN;
              cur_way_q <= cur_way_q + 1'b1;
              if (cur_way_q == LAST_WAY) begin
                cur_index_q <= cur_index_q + 1'b1;
              end
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          wb_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Directed bench for cache_flush_ctrl (WAYS=4, SETS=4); the bench holds the valid/dirty
// arrays and applies clears one posedge after the DUT requests them.
module tb_cache_flush_ctrl;

  localparam int unsigned WAYS = 4;
  localparam int unsigned SETS = 4;
  localparam int unsigned IW   = 2;
  localparam int unsigned WW   = 2;

  logic            clk;
  logic            rst;
  logic            flush_start;
  logic            inv_valid;
  logic            inv_ready;
  logic [IW-1:0]   inv_index;
  logic [WW-1:0]   inv_way;
  logic [IW-1:0]   rd_index;
  logic [WAYS-1:0] valid_in;
  logic [WAYS-1:0] dirty_in;
  logic            clr_we;
  logic [IW-1:0]   clr_index;
  logic [WW-1:0]   clr_way;
  logic            wb_valid;
  logic            wb_ready;
  logic [IW-1:0]   wb_index;
  logic [WW-1:0]   wb_way;
  logic            busy;
  logic            done;

  logic [WAYS-1:0] valid_mem [SETS];
  logic [WAYS-1:0] dirty_mem [SETS];

  assign valid_in = valid_mem[rd_index];
  assign dirty_in = dirty_mem[rd_index];

  cache_flush_ctrl #(
    .WAYS       (WAYS),
    .TOTAL_SIZE (WAYS * SETS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_start (flush_start),
    .inv_valid   (inv_valid),
    .inv_ready   (inv_ready),
    .inv_index   (inv_index),
    .inv_way     (inv_way),
    .rd_index    (rd_index),
    .valid_in    (valid_in),
    .dirty_in    (dirty_in),
    .clr_we      (clr_we),
    .clr_index   (clr_index),
    .clr_way     (clr_way),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_index    (wb_index),
    .wb_way      (wb_way),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int busy_n, done_n, done_at, wb_n, wb_line, wb_unstable, clr_at, rdy_busy_n, viol_n;
  int clr_log [$];
  int stall_left;
  logic last_inv_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    busy_n = 0; done_n = 0; done_at = -1; wb_n = 0; wb_line = -1;
    wb_unstable = 0; clr_at = -1; rdy_busy_n = 0;
    clr_log.delete();
  endtask

  task automatic set_mem(input logic v, input logic d);
    for (int s = 0; s < SETS; s++) begin
      valid_mem[s] = {WAYS{v}};
      dirty_mem[s] = {WAYS{d}};
    end
  endtask

  function automatic int count_valid();
    int n = 0;
    for (int s = 0; s < SETS; s++) n += $countones(valid_mem[s]);
    return n;
  endfunction

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    logic          pend;
    logic [IW-1:0] pi;
    logic [WW-1:0] pw;
    #1;
    if (busy) busy_n++;
    if (done) begin done_n++; done_at = busy_n; end
    if (busy && inv_ready) rdy_busy_n++;
    last_inv_ready = inv_ready;
    if (wb_valid) begin
      wb_n++;
      if (wb_n > 1 && wb_line != int'({wb_index, wb_way})) wb_unstable++;
      wb_line = int'({wb_index, wb_way});
    end
    if (clr_we) begin
      clr_log.push_back(int'({clr_index, clr_way}));
      clr_at = busy_n;
      if (wb_valid && !wb_ready) viol_n++;
    end
    pend = clr_we; pi = clr_index; pw = clr_way;
    @(posedge clk);
    #1;
    if (pend) begin
      valid_mem[pi][pw] = 1'b0;
      dirty_mem[pi][pw] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run_op(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (wb_valid && stall_left > 0) begin
        wb_ready = 1'b0;
        stall_left--;
      end else begin
        wb_ready = wb_valid;
      end
      tick();
      if (done_n > 0) break;
    end
    wb_ready = 1'b0;
    check("op_done_pulses", done_n, 1);
  endtask

  task automatic start_flush();
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush_start = 1'b0; inv_valid = 1'b0; inv_index = '0; inv_way = '0;
    wb_ready = 1'b0; stall_left = 0; viol_n = 0; last_inv_ready = 1'b0;
    set_mem(1'b0, 1'b0);
    clear_stats();
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_clr_we", clr_we, 0);
    check("rst_inv_ready", inv_ready, 0);
    check("rst_rd_index", rd_index, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: all invalid flush
    clear_stats();
    start_flush();
    run_op(40);
    check("t1_busy_cycles", busy_n, 17);
    check("t1_done_at", done_at, 17);
    check("t1_clr_count", clr_log.size(), 0);
    check("t1_wb_count", wb_n, 0);

    // 2: all valid clean flush, clears in (index,way) order
    set_mem(1'b1, 1'b0);
    clear_stats();
    start_flush();
    run_op(40);
    check("t2_clr_count", clr_log.size(), 16);
    for (int i = 0; i < 16 && i < clr_log.size(); i++) check("t2_clr_order", clr_log[i], i);
    check("t2_last_clr_at", clr_at, 16);
    check("t2_done_at", done_at, 17);
    check("t2_valid_left", count_valid(), 0);

    // 3: (2,1) dirty, three stall cycles on wb_ready
    set_mem(1'b1, 1'b0);
    dirty_mem[2][1] = 1'b1;
    clear_stats();
    start_flush();
    stall_left = 3;
    run_op(60);
    check("t3_wb_cycles", wb_n, 4);
    check("t3_wb_line", wb_line, 9);
    check("t3_wb_stable", wb_unstable, 0);
    check("t3_clr_count", clr_log.size(), 16);
    if (clr_log.size() > 10) begin
      check("t3_clr_dirty_line", clr_log[9], 9);
      check("t3_resume_line", clr_log[10], 10);
    end
    check("t3_busy_cycles", busy_n, 21);
    check("t3_dirty_left", dirty_mem[2][1], 0);

    // 4: single-line invalidate of (1,3)
    set_mem(1'b1, 1'b0);
    clear_stats();
    inv_valid = 1'b1; inv_index = 2'd1; inv_way = 2'd3;
    tick();
    check("t4_inv_ready", last_inv_ready, 1);
    inv_valid = 1'b0;
    run_op(10);
    check("t4_busy_cycles", busy_n, 2);
    check("t4_clr_count", clr_log.size(), 1);
    if (clr_log.size() > 0) check("t4_clr_line", clr_log[0], 7);
    check("t4_clr_at", clr_at, 1);
    check("t4_done_at", done_at, 2);
    check("t4_valid_left", count_valid(), 15);
    check("t4_line_cleared", valid_mem[1][3], 0);

    // 5: flush and line request together; flush wins, line accepted after done
    set_mem(1'b0, 1'b0);
    clear_stats();
    inv_valid = 1'b1; inv_index = 2'd1; inv_way = 2'd2;
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
    check("t5_inv_ready_collide", last_inv_ready, 0);
    run_op(40);
    check("t5_flush_busy", busy_n, 17);
    check("t5_ready_while_busy", rdy_busy_n, 0);
    valid_mem[1][2] = 1'b1;
    clear_stats();
    tick();
    check("t5_inv_ready_after", last_inv_ready, 1);
    inv_valid = 1'b0;
    run_op(10);
    check("t5_line_busy", busy_n, 2);
    check("t5_clr_count", clr_log.size(), 1);
    if (clr_log.size() > 0) check("t5_clr_line", clr_log[0], 6);

    // 6: reset during writeback of (0,2)
    set_mem(1'b0, 1'b0);
    valid_mem[0][2] = 1'b1; dirty_mem[0][2] = 1'b1;
    clear_stats();
    start_flush();
    stall_left = 1000;
    for (int c = 0; c < 20; c++) begin
      if (wb_valid) break;
      wb_ready = 1'b0;
      tick();
    end
    stall_left = 0;
    check("t6_wb_reached", wb_valid, 1);
    check("t6_wb_line", int'({wb_index, wb_way}), 2);
    rst = 1'b1;
    #1;
    check("t6_rst_wb_valid", wb_valid, 0);
    check("t6_rst_clr_we", clr_we, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_rd_index", rd_index, 0);
    @(negedge clk);
    rst = 1'b0;
    set_mem(1'b0, 1'b0);
    clear_stats();
    start_flush();
    #1;
    check("t6_restart_index", rd_index, 0);
    check("t6_restart_busy", busy, 1);
    run_op(40);
    check("t6_restart_busy_cycles", busy_n, 17);

    check("clr_with_wb_unready", viol_n, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
